// File: rtl/mem_pkg.sv
// Shared types and defaults for the dual-port synchronous memory.
// Imported by the top level and the storage array.
package mem_pkg;

    typedef enum logic {
        INIT,
        RUN
    } state_e;

    localparam int unsigned DEF_ADDR_W = 13;
    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_DEPTH  = 8192;

    // Addresses at or above depth have no backing storage.
    function automatic logic addr_in_range(
        input logic [31:0] addr,
        input logic [31:0] depth
    );
        return addr < depth;
    endfunction

endpackage

// File: rtl/mem_array_2p.sv
// Dual-port RAM: one write port, two registered read ports.
// Port D reads write-first, port I reads the pre-write contents.
module mem_array_2p #(
    parameter int unsigned IDX_W  = 13,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8192
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              d_re,
    input  logic [IDX_W-1:0]  d_addr,
    output logic [DATA_W-1:0] d_rdata,
    input  logic              i_re,
    input  logic [IDX_W-1:0]  i_addr,
    output logic [DATA_W-1:0] i_rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;

    always_comb begin
        d_rdata_d = d_rdata_q;
        i_rdata_d = i_rdata_q;
        if (d_re) begin
            d_rdata_d = (we && waddr == d_addr) ? wdata : mem_q[d_addr];
        end
        if (i_re) begin
            i_rdata_d = mem_q[i_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        d_rdata_q <= d_rdata_d;
        i_rdata_q <= i_rdata_d;
    end

    assign d_rdata = d_rdata_q;
    assign i_rdata = i_rdata_q;

endmodule

// File: rtl/dual_port_sync_memory.sv
// Dual-port memory: instruction fetch port plus read/write data port,
// with a counted init sweep after reset before requests are accepted.
module dual_port_sync_memory
    import mem_pkg::*;
#(
    parameter int unsigned     ADDR_W   = DEF_ADDR_W,
    parameter int unsigned     DATA_W   = DEF_DATA_W,
    parameter int unsigned     DEPTH    = DEF_DEPTH,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_rd,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_valid,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              d_err,
    output logic              ready
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_LIM = 32'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             i_valid_q, i_valid_d;
    logic             d_valid_q, d_valid_d;
    logic             d_err_q, d_err_d;
    logic             i_zero_q, i_zero_d;
    logic             d_zero_q, d_zero_d;

    logic              acc;
    logic              i_in, d_in;
    logic              i_re, d_re;
    logic              we;
    logic [IDX_W-1:0]  waddr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] arr_i_rdata, arr_d_rdata;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we      = 1'b0;
        waddr   = cnt_q;
        wdata   = INIT_VAL;
        acc     = rst && (state_q == RUN);
        i_in    = addr_in_range(32'(i_addr), DEPTH_LIM);
        d_in    = addr_in_range(32'(d_addr), DEPTH_LIM);

        unique case (state_q)
            INIT: begin
                we    = rst;
                cnt_d = cnt_q + IDX_W'(1);
                if (cnt_q == LAST_IDX) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                we    = acc && d_wr && d_in;
                waddr = d_addr[IDX_W-1:0];
                wdata = d_wdata;
            end
        endcase

        i_re      = acc && i_rd;
        d_re      = acc && d_rd;
        i_valid_d = i_re;
        d_valid_d = d_re;
        d_err_d   = acc && (d_rd || d_wr) && !d_in;
        // Zero flags mask the array so reset and out-of-range reads show 0.
        i_zero_d  = i_re ? !i_in : i_zero_q;
        d_zero_d  = d_re ? !d_in : d_zero_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= INIT;
            cnt_q     <= '0;
            i_valid_q <= 1'b0;
            d_valid_q <= 1'b0;
            d_err_q   <= 1'b0;
            i_zero_q  <= 1'b1;
            d_zero_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            i_valid_q <= i_valid_d;
            d_valid_q <= d_valid_d;
            d_err_q   <= d_err_d;
            i_zero_q  <= i_zero_d;
            d_zero_q  <= d_zero_d;
        end
    end

    mem_array_2p #(
        .IDX_W  (IDX_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk     (clk),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .d_re    (d_re),
        .d_addr  (d_addr[IDX_W-1:0]),
        .d_rdata (arr_d_rdata),
        .i_re    (i_re),
        .i_addr  (i_addr[IDX_W-1:0]),
        .i_rdata (arr_i_rdata)
    );

    assign i_rdata = i_zero_q ? '0 : arr_i_rdata;
    assign d_rdata = d_zero_q ? '0 : arr_d_rdata;
    assign i_valid = i_valid_q;
    assign d_valid = d_valid_q;
    assign d_err   = d_err_q;
    assign ready   = (state_q == RUN);

endmodule

// File: tb/tb_dual_port_sync_memory.sv
// Randomized bench for dual_port_sync_memory against a behavioural model.
module tb_dual_port_sync_memory;

    localparam int AW    = 13;
    localparam int DW    = 8;
    localparam int DEPTH = 4096;
    localparam logic [7:0] IV = 8'hA5;

    logic          clk;
    logic          rst;
    logic          i_rd;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_valid;
    logic          d_rd;
    logic          d_wr;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_valid;
    logic          d_err;
    logic          ready;

    dual_port_sync_memory #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .DEPTH    (DEPTH),
        .INIT_VAL (IV)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_rd    (i_rd),
        .i_addr  (i_addr),
        .i_rdata (i_rdata),
        .i_valid (i_valid),
        .d_rd    (d_rd),
        .d_wr    (d_wr),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_rdata (d_rdata),
        .d_valid (d_valid),
        .d_err   (d_err),
        .ready   (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] ref_mem [DEPTH];
    bit         m_ready;
    int         m_init_left;
    logic [7:0] m_ir, m_dr;
    bit         m_iv, m_dv, m_de;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock: drive, advance the model, then compare after the edge.
    task automatic step(input bit r, input bit ir, input int ia,
                        input bit dr, input bit dw, input int da,
                        input int wd);
        bit din;
        rst     = r;
        i_rd    = ir;
        i_addr  = ia[AW-1:0];
        d_rd    = dr;
        d_wr    = dw;
        d_addr  = da[AW-1:0];
        d_wdata = wd[DW-1:0];
        if (!r) begin
            m_ready     = 0;
            m_init_left = DEPTH;
            m_iv = 0; m_dv = 0; m_de = 0;
            m_ir = 0; m_dr = 0;
        end else if (!m_ready) begin
            m_iv = 0; m_dv = 0; m_de = 0;
            m_init_left--;
            if (m_init_left == 0) begin
                foreach (ref_mem[k]) ref_mem[k] = IV;
                m_ready = 1;
            end
        end else begin
            din  = (da < DEPTH);
            m_iv = ir;
            if (ir) m_ir = (ia < DEPTH) ? ref_mem[ia] : 8'h00;
            if (dw && din) ref_mem[da] = wd[7:0];
            m_dv = dr;
            if (dr) m_dr = din ? ref_mem[da] : 8'h00;
            m_de = (dr || dw) && !din;
        end
        @(posedge clk);
        #1;
        chk("ready",   32'(ready),   32'(m_ready));
        chk("i_valid", 32'(i_valid), 32'(m_iv));
        chk("i_rdata", 32'(i_rdata), 32'(m_ir));
        chk("d_valid", 32'(d_valid), 32'(m_dv));
        chk("d_rdata", 32'(d_rdata), 32'(m_dr));
        chk("d_err",   32'(d_err),   32'(m_de));
    endtask

    function automatic int pick_addr();
        case ($urandom_range(0, 3))
            0:       return int'($urandom_range(0, 7));
            1:       return int'($urandom_range(4090, 4100));
            2:       return int'($urandom_range(0, 8191));
            default: return ($urandom_range(0, 1) == 0) ? 904 : 5000;
        endcase
    endfunction

    task automatic rand_step();
        step(1'b1, 1'($urandom), pick_addr(), 1'($urandom), 1'($urandom),
             pick_addr(), int'($urandom_range(0, 255)));
    endtask

    initial begin
        int k;
        int run;
        rst = 1'b0; i_rd = 0; i_addr = '0; d_rd = 0; d_wr = 0;
        d_addr = '0; d_wdata = '0;

        repeat (3) step(0, 0, 0, 0, 0, 0, 0);
        chk("rst_ready", 32'(ready), 32'd0);

        k = 0;
        while (!ready && k < DEPTH + 10) begin
            rand_step();
            k++;
        end
        chk("init_len", k, DEPTH);

        step(1, 0, 0, 1, 0, 4095, 0);
        chk("rd_last", 32'(d_rdata), 32'hA5);

        step(1, 0, 0, 0, 1, 1000, 130);
        step(1, 1, 1000, 0, 0, 0, 0);
        chk("i_after_wr", 32'(i_rdata), 32'd130);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("i_hold_valid", 32'(i_valid), 32'd0);
        chk("i_hold_data", 32'(i_rdata), 32'd130);

        step(1, 1, 5, 0, 1, 5, 'h3C);
        chk("i_read_first", 32'(i_rdata), 32'hA5);
        step(1, 0, 0, 1, 1, 5, 'h77);
        chk("d_write_first", 32'(d_rdata), 32'h77);

        step(1, 0, 0, 0, 1, 5000, 9);
        chk("oor_wr_err", 32'(d_err), 32'd1);
        step(1, 0, 0, 1, 0, 5000, 0);
        chk("oor_rd_err", 32'(d_err), 32'd1);
        chk("oor_rd_data", 32'(d_rdata), 32'd0);
        step(1, 0, 0, 1, 0, 904, 0);
        chk("alias_904", 32'(d_rdata), 32'hA5);
        step(1, 1, 6000, 0, 0, 0, 0);
        chk("i_oor_data", 32'(i_rdata), 32'd0);
        chk("i_oor_noerr", 32'(d_err), 32'd0);

        for (int a = 0; a < 35; a++) step(1, 0, 0, 0, 1, a, (a * 7 + 3) & 255);
        run = 0;
        for (int a = 0; a < 35; a++) begin
            step(1, 1, a, 0, 0, 0, 0);
            if (i_valid) run++;
            chk("stream_data", 32'(i_rdata), 32'((a * 7 + 3) & 255));
        end
        chk("stream_run", run, 35);
        step(1, 0, 0, 0, 0, 0, 0);

        repeat (3000) rand_step();

        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 7, 'h11);
        k = 1;
        while (!ready && k < DEPTH + 10) begin
            step(1, 0, 0, 0, 0, 0, 0);
            k++;
        end
        chk("reinit_len", k, DEPTH);
        step(1, 0, 0, 1, 0, 7, 0);
        chk("reinit_data", 32'(d_rdata), 32'hA5);

        repeat (500) rand_step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
